// File: rtl/motor_pkg.sv
// Shared types and constants for the motor command scheduler.
// Widths here size the FIFO word, the one-hot Motor bus and the position bank.
package motor_pkg;

    localparam int NUM_MOTOR = 6;
    localparam int PN_W      = 10;
    localparam int POS_W     = 16;
    localparam int MIDX_W    = 3;

    typedef enum logic [2:0] {
        WAIT_HOME,
        IDLE,
        ISSUE,
        WAIT_BUSY,
        RUN,
        DONE,
        ERR
    } sched_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BAD_IDX = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef struct packed {
        logic [MIDX_W-1:0] motor;
        logic              dir;
        logic [PN_W-1:0]   num;
    } cmd_t;

    function automatic logic [NUM_MOTOR-1:0] motorOneHot(input logic [MIDX_W-1:0] idx);
        return NUM_MOTOR'(1) << idx;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with occupancy count; read data is the current head (show-ahead).
// DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       sysclk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_rdata  = r_mem[r_rptr];
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    always_ff @(posedge sysclk) begin
        if (w_doPush) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_doPop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/motor_cmd_sched.sv
// Command scheduler feeding the Pulse stage: queues motion commands, issues them one at
// a time after homing, waits on the Busy handshake and keeps a signed position per motor.
module motor_cmd_sched
    import motor_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BUSY_TO    = 255
) (
    input  logic                    sysclk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [MIDX_W-1:0]       cmd_motor,
    input  logic                    cmd_dir,
    input  logic [PN_W-1:0]         cmd_num,
    output logic [NUM_MOTOR-1:0]    Motor,
    output logic [PN_W-1:0]         PulseNum,
    output logic                    MotorDir,
    input  logic                    Busy,
    input  logic [NUM_MOTOR-1:0]    initFlag,
    input  logic [MIDX_W-1:0]       pos_sel,
    output logic signed [POS_W-1:0] pos_out,
    output logic                    sched_busy,
    output logic                    err,
    output logic [1:0]              err_code,
    input  logic                    err_clr
);

    localparam int CNT_W = $clog2(BUSY_TO + 1);

    sched_state_t                 r_state;
    cmd_t                         r_cur;
    logic [CNT_W-1:0]             r_cnt;
    logic [NUM_MOTOR-1:0]         r_initPrev;
    logic signed [POS_W-1:0]      r_pos [NUM_MOTOR];

    cmd_t                         w_inCmd;
    cmd_t                         w_head;
    logic                         w_full;
    logic                         w_empty;
    logic [$clog2(FIFO_DEPTH):0]  w_count;
    logic                         w_accept;
    logic                         w_badIdx;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_homed;
    logic                         w_timeout;
    logic [NUM_MOTOR-1:0]         w_homeRise;
    logic [POS_W-1:0]             w_delta;

    assign w_inCmd    = '{motor: cmd_motor, dir: cmd_dir, num: cmd_num};
    assign cmd_ready  = !w_full;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_badIdx   = w_accept && (cmd_motor >= MIDX_W'(NUM_MOTOR));
    // Zero-length commands are acknowledged but never reach the queue.
    assign w_push     = w_accept && !w_badIdx && (cmd_num != '0);
    assign w_homed    = &initFlag;
    assign w_pop      = (r_state == IDLE) && w_homed && !w_empty;
    assign w_timeout  = (r_state == WAIT_BUSY) && !Busy && (r_cnt == CNT_W'(BUSY_TO - 1));
    assign w_homeRise = initFlag & ~r_initPrev;
    assign w_delta    = {{(POS_W-PN_W){1'b0}}, r_cur.num};
    assign sched_busy = (r_state != IDLE) || (w_count != '0);
    assign pos_out    = (pos_sel < MIDX_W'(NUM_MOTOR)) ? r_pos[pos_sel] : '0;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_inCmd),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= WAIT_HOME;
            r_cur    <= '0;
            r_cnt    <= '0;
            Motor    <= '0;
            PulseNum <= '0;
            MotorDir <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            // Later assignments win, so a fresh error overrides a same-cycle clear.
            if (err_clr) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end
            if (w_badIdx) begin
                err      <= 1'b1;
                err_code <= ERR_BAD_IDX;
            end
            if (w_timeout) begin
                err      <= 1'b1;
                err_code <= ERR_TIMEOUT;
            end

            case (r_state)
                WAIT_HOME: begin
                    if (w_homed) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (!w_homed) begin
                        r_state <= WAIT_HOME;
                    end else if (w_pop) begin
                        r_cur    <= w_head;
                        Motor    <= motorOneHot(w_head.motor);
                        PulseNum <= w_head.num;
                        MotorDir <= w_head.dir;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (Busy) begin
                        r_state <= RUN;
                    end else if (w_timeout) begin
                        Motor    <= '0;
                        PulseNum <= '0;
                        r_state  <= ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!Busy) begin
                        Motor    <= '0;
                        PulseNum <= '0;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                ERR: begin
                    if (err_clr) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= WAIT_HOME;
                end
            endcase
        end
    end

    // A homing edge zeroes that motor's position and beats a same-cycle DONE update.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_initPrev <= '0;
            for (int i = 0; i < NUM_MOTOR; i++) begin
                r_pos[i] <= '0;
            end
        end else begin
            r_initPrev <= initFlag;
            for (int i = 0; i < NUM_MOTOR; i++) begin
                if (w_homeRise[i]) begin
                    r_pos[i] <= '0;
                end else if ((r_state == DONE) && (r_cur.motor == MIDX_W'(i))) begin
                    r_pos[i] <= r_cur.dir ? (r_pos[i] - w_delta) : (r_pos[i] + w_delta);
                end
            end
        end
    end

endmodule

// File: tb/tb_motor_cmd_sched.sv
// Directed bench for motor_cmd_sched: homing hold, ordered issue, FIFO backpressure,
// bad index, Busy timeout recovery, home clear and asynchronous reset.
module tb_motor_cmd_sched;

    logic               sysclk;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_motor;
    logic               cmd_dir;
    logic [9:0]         cmd_num;
    logic [5:0]         Motor;
    logic [9:0]         PulseNum;
    logic               MotorDir;
    logic               Busy;
    logic [5:0]         initFlag;
    logic [2:0]         pos_sel;
    logic signed [15:0] pos_out;
    logic               sched_busy;
    logic               err;
    logic [1:0]         err_code;
    logic               err_clr;

    int checks   = 0;
    int failures = 0;

    motor_cmd_sched dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_motor  (cmd_motor),
        .cmd_dir    (cmd_dir),
        .cmd_num    (cmd_num),
        .Motor      (Motor),
        .PulseNum   (PulseNum),
        .MotorDir   (MotorDir),
        .Busy       (Busy),
        .initFlag   (initFlag),
        .pos_sel    (pos_sel),
        .pos_out    (pos_out),
        .sched_busy (sched_busy),
        .err        (err),
        .err_code   (err_code),
        .err_clr    (err_clr)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=expired required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] motor, input logic dir, input logic [9:0] num);
        int n;
        n = 0;
        @(negedge sysclk);
        while (!cmd_ready && n < 50) begin
            @(negedge sysclk);
            n++;
        end
        if (n >= 50) checkOutput("push_ready_bound", 32'(cmd_ready), 32'd1);
        cmd_motor = motor;
        cmd_dir   = dir;
        cmd_num   = num;
        cmd_valid = 1'b1;
        @(posedge sysclk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic readPos(input logic [2:0] sel, output logic [15:0] val);
        pos_sel = sel;
        #1 val = pos_out;
    endtask

    task automatic waitIssue(input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge sysclk);
            if (Motor != '0) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic doCommandCycle(input string tag, input int busyLen, input logic [5:0] expMotor,
                                  input logic [9:0] expNum, input logic expDir);
        bit found;
        waitIssue(40, found);
        checkOutput({tag, "_issued"}, 32'(found), 32'd1);
        checkOutput({tag, "_motor"}, 32'(Motor), 32'(expMotor));
        checkOutput({tag, "_num"}, 32'(PulseNum), 32'(expNum));
        checkOutput({tag, "_dir"}, 32'(MotorDir), 32'(expDir));
        if (found) begin
            Busy = 1'b1;
            repeat (busyLen) @(negedge sysclk);
            Busy = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] posVal;
        bit          found;
        int          n;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_motor = '0;
        cmd_dir   = 1'b0;
        cmd_num   = '0;
        Busy      = 1'b0;
        initFlag  = '0;
        pos_sel   = '0;
        err_clr   = 1'b0;

        repeat (2) @(negedge sysclk);
        checkOutput("rst_motor", 32'(Motor), 32'd0);
        checkOutput("rst_pulsenum", 32'(PulseNum), 32'd0);
        checkOutput("rst_dir", 32'(MotorDir), 32'd0);
        checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_err", 32'({err, err_code}), 32'd0);
        checkOutput("rst_schedbusy", 32'(sched_busy), 32'd1);
        readPos(3'd0, posVal);
        checkOutput("rst_pos0", 32'(posVal), 32'd0);
        rst_n = 1'b1;

        // Test 1: command held until homing completes
        applyStimulus(3'd1, 1'b0, 10'd5);
        repeat (5) @(negedge sysclk);
        checkOutput("t1_hold_motor", 32'(Motor), 32'd0);
        initFlag = 6'b111111;
        waitIssue(3, found);
        checkOutput("t1_issue_within3", 32'(found), 32'd1);
        doCommandCycle("t1", 50, 6'b000010, 10'd5, 1'b0);
        repeat (3) @(negedge sysclk);
        checkOutput("t1_motor_after", 32'(Motor), 32'd0);
        checkOutput("t1_pulsenum_after", 32'(PulseNum), 32'd0);
        readPos(3'd1, posVal);
        checkOutput("t1_pos1", 32'(posVal), 32'd5);

        // Re-home motor 1 so test 2 starts from zero
        @(negedge sysclk);
        initFlag = 6'b111101;
        @(negedge sysclk);
        checkOutput("rehome_schedbusy", 32'(sched_busy), 32'd1);
        initFlag = 6'b111111;
        repeat (3) @(negedge sysclk);
        readPos(3'd1, posVal);
        checkOutput("rehome_pos1", 32'(posVal), 32'd0);

        // Test 2: three back-to-back commands issue in order
        checkOutput("t2_ready_a", 32'(cmd_ready), 32'd1);
        applyStimulus(3'd1, 1'b0, 10'd5);
        checkOutput("t2_ready_b", 32'(cmd_ready), 32'd1);
        applyStimulus(3'd1, 1'b1, 10'd2);
        checkOutput("t2_ready_c", 32'(cmd_ready), 32'd1);
        applyStimulus(3'd3, 1'b0, 10'd5);
        checkOutput("t2_ready_d", 32'(cmd_ready), 32'd1);
        doCommandCycle("t2a", 3, 6'b000010, 10'd5, 1'b0);
        doCommandCycle("t2b", 3, 6'b000010, 10'd2, 1'b1);
        doCommandCycle("t2c", 3, 6'b001000, 10'd5, 1'b0);
        repeat (3) @(negedge sysclk);
        readPos(3'd1, posVal);
        checkOutput("t2_pos1", 32'(posVal), 32'd3);
        readPos(3'd3, posVal);
        checkOutput("t2_pos3", 32'(posVal), 32'd5);

        // Test 3: FIFO fills behind a running command; fifth push waits for a pop
        applyStimulus(3'd4, 1'b0, 10'd10);
        waitIssue(20, found);
        checkOutput("t3_issue_first", 32'(found), 32'd1);
        Busy = 1'b1;
        repeat (2) @(negedge sysclk);
        applyStimulus(3'd4, 1'b0, 10'd1);
        applyStimulus(3'd4, 1'b0, 10'd2);
        applyStimulus(3'd4, 1'b0, 10'd3);
        applyStimulus(3'd4, 1'b0, 10'd4);
        @(negedge sysclk);
        checkOutput("t3_ready_full", 32'(cmd_ready), 32'd0);
        cmd_motor = 3'd4;
        cmd_dir   = 1'b0;
        cmd_num   = 10'd5;
        cmd_valid = 1'b1;
        repeat (3) @(negedge sysclk);
        checkOutput("t3_ready_still_full", 32'(cmd_ready), 32'd0);
        Busy = 1'b0;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge sysclk);
            n++;
        end
        checkOutput("t3_ready_after_pop", 32'(cmd_ready), 32'd1);
        checkOutput("t3_pop_latency", 32'(n), 32'd3);
        @(posedge sysclk);
        #1 cmd_valid = 1'b0;
        doCommandCycle("t3n1", 2, 6'b010000, 10'd1, 1'b0);
        doCommandCycle("t3n2", 2, 6'b010000, 10'd2, 1'b0);
        doCommandCycle("t3n3", 2, 6'b010000, 10'd3, 1'b0);
        doCommandCycle("t3n4", 2, 6'b010000, 10'd4, 1'b0);
        doCommandCycle("t3n5", 2, 6'b010000, 10'd5, 1'b0);
        repeat (3) @(negedge sysclk);
        readPos(3'd4, posVal);
        checkOutput("t3_pos4", 32'(posVal), 32'd25);

        // Test 4: bad index flags an error, zero-length is dropped, scheduling continues
        applyStimulus(3'd6, 1'b0, 10'd3);
        @(negedge sysclk);
        checkOutput("t4_err", 32'(err), 32'd1);
        checkOutput("t4_errcode", 32'(err_code), 32'd1);
        checkOutput("t4_queue_empty", 32'(sched_busy), 32'd0);
        applyStimulus(3'd2, 1'b0, 10'd0);
        repeat (3) @(negedge sysclk);
        checkOutput("t4_zero_len_motor", 32'(Motor), 32'd0);
        checkOutput("t4_zero_len_busy", 32'(sched_busy), 32'd0);
        applyStimulus(3'd5, 1'b0, 10'd7);
        doCommandCycle("t4", 2, 6'b100000, 10'd7, 1'b0);
        checkOutput("t4_err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        @(negedge sysclk);
        err_clr = 1'b0;
        checkOutput("t4_err_cleared", 32'({err, err_code}), 32'd0);
        repeat (3) @(negedge sysclk);
        readPos(3'd5, posVal);
        checkOutput("t4_pos5", 32'(posVal), 32'd7);

        // Test 5: Busy never rises, timeout parks the scheduler in ERR
        applyStimulus(3'd0, 1'b0, 10'd9);
        waitIssue(20, found);
        checkOutput("t5_issue", 32'(found), 32'd1);
        repeat (200) @(negedge sysclk);
        checkOutput("t5_no_early_err", 32'(err), 32'd0);
        checkOutput("t5_motor_held", 32'(Motor), 32'd1);
        n = 0;
        while (!err && n < 100) begin
            @(negedge sysclk);
            n++;
        end
        checkOutput("t5_err", 32'(err), 32'd1);
        checkOutput("t5_errcode", 32'(err_code), 32'd2);
        checkOutput("t5_motor_zero", 32'(Motor), 32'd0);
        checkOutput("t5_pulsenum_zero", 32'(PulseNum), 32'd0);
        applyStimulus(3'd0, 1'b0, 10'd4);
        repeat (10) @(negedge sysclk);
        checkOutput("t5_no_issue_in_err", 32'(Motor), 32'd0);
        checkOutput("t5_schedbusy", 32'(sched_busy), 32'd1);
        readPos(3'd0, posVal);
        checkOutput("t5_pos0_unchanged", 32'(posVal), 32'd0);
        err_clr = 1'b1;
        @(negedge sysclk);
        err_clr = 1'b0;
        checkOutput("t5_err_cleared", 32'({err, err_code}), 32'd0);
        doCommandCycle("t5", 2, 6'b000001, 10'd4, 1'b0);
        repeat (3) @(negedge sysclk);
        readPos(3'd0, posVal);
        checkOutput("t5_pos0", 32'(posVal), 32'd4);

        // Test 6: negative position, home clear, asynchronous reset during RUN
        applyStimulus(3'd2, 1'b1, 10'd7);
        doCommandCycle("t6", 2, 6'b000100, 10'd7, 1'b1);
        repeat (3) @(negedge sysclk);
        readPos(3'd2, posVal);
        checkOutput("t6_pos2_neg", 32'(posVal), 32'h0000FFF9);
        initFlag = 6'b111011;
        @(negedge sysclk);
        initFlag = 6'b111111;
        repeat (3) @(negedge sysclk);
        readPos(3'd2, posVal);
        checkOutput("t6_pos2_homed", 32'(posVal), 32'd0);
        readPos(3'd5, posVal);
        checkOutput("t6_pos5_kept", 32'(posVal), 32'd7);

        applyStimulus(3'd7, 1'b0, 10'd1);
        applyStimulus(3'd3, 1'b1, 10'd2);
        waitIssue(20, found);
        Busy = 1'b1;
        repeat (3) @(negedge sysclk);
        applyStimulus(3'd1, 1'b0, 10'd3);
        @(negedge sysclk);
        checkOutput("t6_run_motor", 32'(Motor), 32'b001000);
        checkOutput("t6_run_dir", 32'(MotorDir), 32'd1);
        checkOutput("t6_run_err", 32'(err), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_areset_motor", 32'(Motor), 32'd0);
        checkOutput("t6_areset_pulsenum", 32'(PulseNum), 32'd0);
        checkOutput("t6_areset_dir", 32'(MotorDir), 32'd0);
        checkOutput("t6_areset_err", 32'({err, err_code}), 32'd0);
        checkOutput("t6_areset_ready", 32'(cmd_ready), 32'd1);
        readPos(3'd3, posVal);
        checkOutput("t6_areset_pos3", 32'(posVal), 32'd0);
        Busy = 1'b0;
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (6) @(negedge sysclk);
        checkOutput("t6_queue_lost", 32'(sched_busy), 32'd0);
        checkOutput("t6_no_issue", 32'(Motor), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
